instr_mem_arbiter: RTL
======================

Name: instr_mem_arbiter

Overview:
- Two-requester arbiter in front of the instruction memory wrapper (instruction RAM plus boot ROM). Requester 0 is the core instruction-fetch port; requester 1 is the loader/debug port used for program download and readback.
- Uses the req/gnt/rvalid protocol with a fixed 1-cycle read latency from the memory.
- Provides starvation-bounded priority, boot-region write protection, and rdata/rvalid routing back to the granted requester.

Parameters:
- ADDR_WIDTH, 16, byte-address width at the memory side; the MSB selects the boot region.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits wide.
- MAX_BURST, 8, maximum consecutive loader grants while the core is requesting; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- core_req_i  in  1  core fetch request
- core_addr_i  in  ADDR_WIDTH  core address
- core_gnt_o  out  1  core grant
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  DATA_WIDTH  core read data
- ldr_req_i  in  1  loader request
- ldr_addr_i  in  ADDR_WIDTH  loader address
- ldr_we_i  in  1  loader write enable
- ldr_be_i  in  DATA_WIDTH/8  loader byte enables
- ldr_wdata_i  in  DATA_WIDTH  loader write data
- ldr_gnt_o  out  1  loader grant
- ldr_rvalid_o  out  1  loader response valid (reads and writes)
- ldr_rdata_o  out  DATA_WIDTH  loader read data
- ldr_err_o  out  1  qualifies ldr_rvalid_o: rejected boot-region write
- mem_en_o  out  1  memory enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_en_o
- bypass_en_i  in  1  test bypass; while high, core is always winner, loader never granted

Behaviour:
- Reset (rst high, async):
  - All *_o are 0.
  - owner_q=NONE, burst_cnt=0, err_q=0.
- Grant logic is combinational in the same cycle as req; at most one grant per cycle.
- Core is never allowed a write: mem_we_o=0 and mem_be_o='1 when the core is granted.
- Arbitration:
  - Loader has default priority.
  - Exception: if core_req_i=1 and burst_cnt==MAX_BURST, the core wins.
  - Single requester always wins.
- burst_cnt:
  - Increments (saturating at MAX_BURST) on each loader grant while core_req_i=1.
  - Clears on any core grant, or any cycle with core_req_i=0.
- Memory side on grant: mem_en_o=1, and mem_addr/we/be/wdata are driven from the winner.
- Boot-region write protection:
  - A loader write with ldr_addr_i[ADDR_WIDTH-1]=1 is granted, but mem_en_o=0 and mem_we_o=0.
  - Next cycle: ldr_rvalid_o=1 with ldr_err_o=1, ldr_rdata_o=0.
- Response pipeline:
  - owner_q registers the winner (NONE/CORE/LDR); err_q registers the rejected-write flag.
  - Cycle N+1 after a grant: the owner's rvalid_o=1 and rdata_o=mem_rdata_i. The other requester's rdata_o holds 0.
  - Loader writes also get rvalid (with ldr_err_o=0 when accepted).
- Back-to-back: a new grant is allowed every cycle; the response of grant N and grant N+1 overlap by design (1-deep pipeline).
- Simultaneous events: req deasserting in the grant cycle is not allowed (protocol: req held until gnt). Assertion required in the bench.
- bypass_en_i=1: ldr_gnt_o=0, and burst_cnt is held.
- Reset mid-transaction: any pending rvalid is dropped; no response is issued after reset release.

Decomposition:
- Shared package RISCV_MCU_CONFIG gets:
  - typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_LDR} instr_owner_t
  - localparam INSTR_ARB_MAX_BURST=8
- No sub-module. Single flat module of about 180 lines: combinational arbiter plus owner/err/burst registers.

Test Plan:
- Loader only, write 0xDEADBEEF to 0x0010, then read 0x0010 -> gnt the same cycle; rvalid the next cycle; read returns 0xDEADBEEF, err=0.
- Core and loader request continuously with MAX_BURST=8 -> grant pattern is 8 loader grants, 1 core grant, repeating; core gnt never waits more than 8 cycles.
- Loader write to 0x8004 (boot bit set) -> mem_en_o=0 that cycle; next cycle ldr_rvalid_o=1, ldr_err_o=1, rdata=0.
- Core reads 0x0000, 0x0004, 0x0008 back-to-back, loader idle -> three consecutive gnt; rvalid on cycles 2..4; data matches preloaded RAM.
- bypass_en_i=1 with both requesting for 20 cycles -> ldr_gnt_o stays 0; core granted every cycle.
- rst asserted the cycle after a loader read grant -> ldr_rvalid_o=0 immediately and stays 0 after release; owner_q=NONE.

Source files
------------

// File: rtl/instr_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_arbiter_pkg
// Shared types and constants for the instruction-memory arbiter.
//   instr_owner_t        : which requester owns the response slot next cycle
//   INSTR_ARB_MAX_BURST  : default loader burst limit while the core waits
//   INSTR_ARB_ADDR_WIDTH : default memory-side byte-address width
//   INSTR_ARB_DATA_WIDTH : default data width
//   burst_sat_inc()      : saturating increment used by the burst counter
// ---------------------------------------------------------------------------
package instr_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_LDR  = 2'd2
  } instr_owner_t;

  localparam int INSTR_ARB_MAX_BURST  = 8;
  localparam int INSTR_ARB_ADDR_WIDTH = 16;
  localparam int INSTR_ARB_DATA_WIDTH = 32;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [7:0] burst_sat_inc(input logic [7:0] value,
                                               input logic [7:0] limit);
    logic [7:0] result;
    result = value;
    if (value < limit) begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// instr_mem_arbiter_if
// Bundles every bus signal around the arbiter: the core fetch port, the
// loader/debug port, the memory-side port and the test bypass.
//   slave  modport : the arbiter's view (requests/mem_rdata in, grants out)
//   master modport : the environment's view (drives requests and mem data)
// Signal suffixes are written from the arbiter's point of view.
// ---------------------------------------------------------------------------
interface instr_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // core fetch port
  logic                  core_req_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic                  core_gnt_o;
  logic                  core_rvalid_o;
  logic [DATA_WIDTH-1:0] core_rdata_o;

  // loader/debug port
  logic                  ldr_req_i;
  logic [ADDR_WIDTH-1:0] ldr_addr_i;
  logic                  ldr_we_i;
  logic [BE_WIDTH-1:0]   ldr_be_i;
  logic [DATA_WIDTH-1:0] ldr_wdata_i;
  logic                  ldr_gnt_o;
  logic                  ldr_rvalid_o;
  logic [DATA_WIDTH-1:0] ldr_rdata_o;
  logic                  ldr_err_o;

  // memory side
  logic                  mem_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [BE_WIDTH-1:0]   mem_be_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  // test bypass
  logic                  bypass_en_i;

  modport slave (
    input  core_req_i, core_addr_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    input  ldr_req_i, ldr_addr_i, ldr_we_i, ldr_be_i, ldr_wdata_i,
    output ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o, ldr_err_o,
    output mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i,
    input  bypass_en_i
  );

  modport master (
    output core_req_i, core_addr_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    output ldr_req_i, ldr_addr_i, ldr_we_i, ldr_be_i, ldr_wdata_i,
    input  ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o, ldr_err_o,
    input  mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i,
    output bypass_en_i
  );

endinterface

// File: rtl/instr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// instr_mem_arbiter
// Two-requester arbiter in front of the instruction RAM / boot ROM wrapper.
// Requester 0 is the core fetch port (read only), requester 1 is the
// loader/debug port (read/write). The memory has a fixed 1-cycle read
// latency; grants are combinational and responses come back one cycle later.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : instr_mem_arbiter_if.slave (core, loader, memory and bypass signals)
//
// Behaviour summary:
//   - loader has default priority; once the loader has been granted MAX_BURST
//     times in a row while the core waits, the core wins one cycle
//   - loader writes with the address MSB set (boot region) are granted but
//     never reach the memory, and are answered with ldr_err_o
//   - bypass_en_i forces the core to be the only possible winner
// ---------------------------------------------------------------------------
module instr_mem_arbiter
  import instr_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = INSTR_ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = INSTR_ARB_DATA_WIDTH,
  parameter int MAX_BURST  = INSTR_ARB_MAX_BURST
) (
  input logic                clk,
  input logic                rst,
  instr_mem_arbiter_if.slave bus
);

  localparam int         BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  // registered state
  instr_owner_t owner_q, owner_d;
  logic         err_q, err_d;
  logic [7:0]   burst_q, burst_d;

  // combinational arbitration results
  logic core_gnt;
  logic ldr_gnt;
  logic boot_wr;
  logic core_turn;

  // A loader write into the boot region is accepted on the bus but blocked
  // from the memory.
  assign boot_wr   = bus.ldr_we_i & bus.ldr_addr_i[ADDR_WIDTH-1];

  // Core has waited out a full loader burst.
  assign core_turn = bus.core_req_i & (burst_q == BURST_LIM);

  // -------------------------------------------------------------------------
  // Grant selection. Outputs are forced low while reset is asserted so that
  // every output reads zero during reset, not just the registered ones.
  // -------------------------------------------------------------------------
  always_comb begin
    core_gnt = 1'b0;
    ldr_gnt  = 1'b0;
    if (!rst) begin
      if (bus.bypass_en_i) begin
        core_gnt = bus.core_req_i;
      end else if (bus.ldr_req_i && !core_turn) begin
        ldr_gnt = 1'b1;
      end else if (bus.core_req_i) begin
        core_gnt = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Memory-side mux. The core can only read: write enable stays low and all
  // byte lanes are enabled.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mem_en_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_wdata_o = '0;
    if (core_gnt) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_addr_o  = bus.core_addr_i;
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = '1;
      bus.mem_wdata_o = '0;
    end else if (ldr_gnt) begin
      bus.mem_en_o    = ~boot_wr;
      bus.mem_addr_o  = bus.ldr_addr_i;
      bus.mem_we_o    = bus.ldr_we_i & ~boot_wr;
      bus.mem_be_o    = bus.ldr_be_i;
      bus.mem_wdata_o = bus.ldr_wdata_i;
    end
  end

  assign bus.core_gnt_o = core_gnt;
  assign bus.ldr_gnt_o  = ldr_gnt;

  // -------------------------------------------------------------------------
  // Next-state logic for owner, error flag and burst counter.
  // -------------------------------------------------------------------------
  always_comb begin
    owner_d = OWN_NONE;
    if (core_gnt) begin
      owner_d = OWN_CORE;
    end else if (ldr_gnt) begin
      owner_d = OWN_LDR;
    end
  end

  assign err_d = ldr_gnt & boot_wr;

  // The counter only measures how long the core has been kept waiting, so it
  // restarts whenever the core is served or stops asking. Bypass freezes it
  // so that normal arbitration resumes where it left off.
  always_comb begin
    burst_d = burst_q;
    if (bus.bypass_en_i) begin
      burst_d = burst_q;
    end else if (!bus.core_req_i || core_gnt) begin
      burst_d = 8'd0;
    end else if (ldr_gnt) begin
      burst_d = burst_sat_inc(burst_q, BURST_LIM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      burst_q <= 8'd0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      burst_q <= burst_d;
    end
  end

  // -------------------------------------------------------------------------
  // Response routing. Only the owner of the previous grant sees rvalid and
  // memory data; the other requester's data bus is held at zero. A rejected
  // boot write returns zero data with the error flag set.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.core_rvalid_o = (owner_q == OWN_CORE);
    bus.core_rdata_o  = '0;
    if (owner_q == OWN_CORE) begin
      bus.core_rdata_o = bus.mem_rdata_i;
    end
  end

  always_comb begin
    bus.ldr_rvalid_o = (owner_q == OWN_LDR);
    bus.ldr_err_o    = (owner_q == OWN_LDR) & err_q;
    bus.ldr_rdata_o  = '0;
    if ((owner_q == OWN_LDR) && !err_q) begin
      bus.ldr_rdata_o = bus.mem_rdata_i;
    end
  end

endmodule
